// File: rtl/circle_set_counter_pkg.sv
// Shared types and width helpers for the circle set counter.
// Optional feature macro: CIRCLE_SET_ROWMASK_EN (adds a per-row hit mask output).
package circle_set_pkg;

    // Set-combination modes applied per lattice point.
    typedef enum logic [2:0] {
        MODE_A        = 3'd0,
        MODE_AND      = 3'd1,
        MODE_XOR      = 3'd2,
        MODE_EXACT2   = 3'd3,
        MODE_OR_ALL   = 3'd4,
        MODE_AND_ALL  = 3'd5,
        MODE_ATLEAST2 = 3'd6,
        MODE_RSVD     = 3'd7
    } mode_e;

    // Scan controller states.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Width of a squared signed (coord_w+1)-bit difference.
    function automatic int sq_w(input int coord_w);
        return 2 * coord_w + 2;
    endfunction

    // Width of the sum of two squares.
    function automatic int sum_w(input int coord_w);
        return sq_w(coord_w) + 1;
    endfunction

    // Width of a squared radius.
    function automatic int r2_w(input int coord_w);
        return 2 * coord_w;
    endfunction

endpackage

// File: rtl/circle_set_counter_if.sv
// Command/result bundle between the host command interface and the counter.
// Optional feature macro: CIRCLE_SET_ROWMASK_EN (adds row_mask / row_mask_vld).
interface circle_set_counter_if #(
    parameter int GRID    = 8,
    parameter int COORD_W = 4,
    parameter int N_CIRC  = 3,
    parameter int CNT_W   = $clog2(GRID * GRID + 1)
);
    logic                          en;
    logic [N_CIRC*2*COORD_W-1:0]   central;
    logic [N_CIRC*COORD_W-1:0]     radius;
    logic [2:0]                    mode;
    logic                          busy;
    logic                          valid;
    logic [CNT_W-1:0]              candidate;
`ifdef CIRCLE_SET_ROWMASK_EN
    logic [GRID-1:0]               row_mask;
    logic                          row_mask_vld;
`endif

    // Host side: issues jobs, observes results.
    modport master (
        output en, central, radius, mode,
        input  busy, valid, candidate
`ifdef CIRCLE_SET_ROWMASK_EN
        , input row_mask, row_mask_vld
`endif
    );

    // Counter side: accepts jobs, produces results.
    modport slave (
        input  en, central, radius, mode,
        output busy, valid, candidate
`ifdef CIRCLE_SET_ROWMASK_EN
        , output row_mask, row_mask_vld
`endif
    );

endinterface

// File: rtl/circle_set_counter_hit_row.sv
// Combinational row evaluator: for one circle and one row y, flags every
// column x in 1..GRID with (x-cx)^2 + (y-cy)^2 <= r^2. Full-width math,
// no truncation.
module circle_hit_row
    import circle_set_pkg::*;
#(
    parameter int GRID    = 8,
    parameter int COORD_W = 4
) (
    input  logic [COORD_W-1:0] i_cx,
    input  logic [COORD_W-1:0] i_cy,
    input  logic [COORD_W-1:0] i_r,
    input  logic [COORD_W-1:0] i_row,
    output logic [GRID-1:0]    o_hit
);
    localparam int SQ_W  = sq_w(COORD_W);
    localparam int SUM_W = sum_w(COORD_W);
    localparam int R2_W  = r2_w(COORD_W);

    logic signed [COORD_W:0] w_dy;
    logic [COORD_W:0]        w_dy_abs;
    logic [SQ_W-1:0]         w_dy2;
    logic [R2_W-1:0]         w_r2;

    // Row term is shared by every column of this circle.
    assign w_dy     = $signed({1'b0, i_row}) - $signed({1'b0, i_cy});
    assign w_dy_abs = w_dy[COORD_W] ? $unsigned(-w_dy) : $unsigned(w_dy);
    assign w_dy2    = SQ_W'(w_dy_abs) * SQ_W'(w_dy_abs);
    assign w_r2     = R2_W'(i_r) * R2_W'(i_r);

    for (genvar gx = 0; gx < GRID; gx++) begin : g_col
        logic signed [COORD_W:0] w_dx;
        logic [COORD_W:0]        w_dx_abs;
        logic [SQ_W-1:0]         w_dx2;
        logic [SUM_W-1:0]        w_sum;

        // Column gx holds lattice x = gx+1.
        assign w_dx       = $signed({1'b0, COORD_W'(gx + 1)}) - $signed({1'b0, i_cx});
        assign w_dx_abs   = w_dx[COORD_W] ? $unsigned(-w_dx) : $unsigned(w_dx);
        assign w_dx2      = SQ_W'(w_dx_abs) * SQ_W'(w_dx_abs);
        assign w_sum      = SUM_W'(w_dx2) + SUM_W'(w_dy2);
        assign o_hit[gx]  = (w_sum <= SUM_W'(w_r2));
    end

endmodule

// File: rtl/circle_set_counter.sv
// circle_set_counter: scans a GRIDxGRID lattice one row per cycle and counts
// points satisfying a set-combination of up to N_CIRC circles.
// Optional feature macro: CIRCLE_SET_ROWMASK_EN (exports each row's combined
// hit vector with a one-cycle valid).
module circle_set_counter
    import circle_set_pkg::*;
#(
    parameter int GRID    = 8,
    parameter int COORD_W = 4,
    parameter int N_CIRC  = 3,
    parameter int CNT_W   = $clog2(GRID * GRID + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    circle_set_counter_if.slave   bus
);
    localparam int NH_W = $clog2(N_CIRC + 1);

    state_e                        r_state;
    logic [COORD_W-1:0]            r_row;
    logic [CNT_W-1:0]              r_acc;
    logic [CNT_W-1:0]              r_candidate;
    logic                          r_busy;
    logic                          r_valid;
    logic [N_CIRC*2*COORD_W-1:0]   r_central;
    logic [N_CIRC*COORD_W-1:0]     r_radius;
    mode_e                         r_mode;
`ifdef CIRCLE_SET_ROWMASK_EN
    logic [GRID-1:0]               r_row_mask;
    logic                          r_row_mask_vld;
`endif

    logic [GRID-1:0]               w_hit [N_CIRC];
    logic [NH_W-1:0]               w_nhits [GRID];
    logic [GRID-1:0]               w_comb;
    logic [CNT_W-1:0]              w_row_cnt;
    logic                          w_accept;

    // Circle k occupies slot k counted from the most-significant end; x above y.
    for (genvar gk = 0; gk < N_CIRC; gk++) begin : g_circ
        circle_hit_row #(
            .GRID    (GRID),
            .COORD_W (COORD_W)
        ) u_hit (
            .i_cx  (r_central[(N_CIRC-gk)*2*COORD_W-1 -: COORD_W]),
            .i_cy  (r_central[(N_CIRC-gk)*2*COORD_W-COORD_W-1 -: COORD_W]),
            .i_r   (r_radius[(N_CIRC-gk)*COORD_W-1 -: COORD_W]),
            .i_row (r_row),
            .o_hit (w_hit[gk])
        );
    end

    // Per-column count of circles covering the point.
    always_comb begin
        // NOTE: every combinational output gets a default before any loop or
        // branch so no path leaves it unassigned and no latch is inferred.
        for (int x = 0; x < GRID; x++) begin
            w_nhits[x] = '0;
            for (int k = 0; k < N_CIRC; k++) begin
                w_nhits[x] = w_nhits[x] + NH_W'(w_hit[k][x]);
            end
        end
    end

    // Apply the latched set-combination mode column by column.
    always_comb begin
        w_comb = '0;
        for (int x = 0; x < GRID; x++) begin
            case (r_mode)
                MODE_A:        w_comb[x] = w_hit[0][x];
                MODE_AND:      w_comb[x] = w_hit[0][x] & w_hit[1][x];
                MODE_XOR:      w_comb[x] = w_hit[0][x] ^ w_hit[1][x];
                MODE_EXACT2:   w_comb[x] = (2'(w_hit[0][x]) + 2'(w_hit[1][x])
                                           + 2'(w_hit[2][x])) == 2'd2;
                MODE_OR_ALL:   w_comb[x] = (w_nhits[x] != '0);
                MODE_AND_ALL:  w_comb[x] = (w_nhits[x] == NH_W'(N_CIRC));
                MODE_ATLEAST2: w_comb[x] = (w_nhits[x] >= NH_W'(2));
                default:       w_comb[x] = 1'b0;
            endcase
        end
    end

    // Popcount of the current row's combined hits.
    always_comb begin
        w_row_cnt = '0;
        for (int x = 0; x < GRID; x++) begin
            w_row_cnt = w_row_cnt + CNT_W'(w_comb[x]);
        end
    end

    assign w_accept = (r_state == IDLE) && bus.en;

    // Job operands are captured on accept; they are never read before that, so
    // they carry no reset.
    always_ff @(posedge clk) begin
        // NOTE: operand registers are deliberately left out of reset: every
        // consumer is gated by the SCAN state, which is only reached after a load.
        if (w_accept) begin
            r_central <= bus.central;
            r_radius  <= bus.radius;
            r_mode    <= mode_e'(bus.mode);
        end
    end

    // Scan controller: row sequencing, accumulation and result handshake.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_acc       <= '0;
            r_candidate <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
`ifdef CIRCLE_SET_ROWMASK_EN
            r_row_mask     <= '0;
            r_row_mask_vld <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
`ifdef CIRCLE_SET_ROWMASK_EN
            r_row_mask_vld <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        r_row   <= COORD_W'(1);
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_acc <= r_acc + w_row_cnt;
`ifdef CIRCLE_SET_ROWMASK_EN
                    r_row_mask     <= w_comb;
                    r_row_mask_vld <= 1'b1;
`endif
                    if (r_row == COORD_W'(GRID)) begin
                        r_candidate <= r_acc + w_row_cnt;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_row <= r_row + COORD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.valid     = r_valid;
    assign bus.candidate = r_candidate;
`ifdef CIRCLE_SET_ROWMASK_EN
    assign bus.row_mask     = r_row_mask;
    assign bus.row_mask_vld = r_row_mask_vld;
`endif

endmodule

// File: tb/tb_circle_set_counter.sv
// Directed self-checking bench for circle_set_counter (GRID=8, COORD_W=4,
// N_CIRC=3). Row-mask checks are compiled in when CIRCLE_SET_ROWMASK_EN is set.
module tb_circle_set_counter;
    localparam int GRID    = 8;
    localparam int COORD_W = 4;
    localparam int N_CIRC  = 3;
    localparam int CNT_W   = $clog2(GRID * GRID + 1);
    localparam int BOUND   = 40;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    circle_set_counter_if #(
        .GRID(GRID), .COORD_W(COORD_W), .N_CIRC(N_CIRC), .CNT_W(CNT_W)
    ) bus_if ();

    circle_set_counter #(
        .GRID(GRID), .COORD_W(COORD_W), .N_CIRC(N_CIRC), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: presents a job for one edge, returns at the next negedge.
    task automatic drive_job(input logic [3:0] ax, ay, ar, bx, by, br, cx, cy, cr,
                             input logic [2:0] m);
        bus_if.central = {ax, ay, bx, by, cx, cy};
        bus_if.radius  = {ar, br, cr};
        bus_if.mode    = m;
        bus_if.en      = 1'b1;
        @(negedge clk);
        bus_if.en      = 1'b0;
    endtask

    // Waits (bounded) for valid, counting negedges from 'start' and busy cycles.
    task automatic wait_valid(input int start, output int lat, output bit seen,
                              output int busy_cyc);
        lat      = start;
        seen     = 1'b0;
        busy_cyc = 0;
        while (!seen && lat < BOUND) begin
            if (bus_if.valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus_if.busy === 1'b1) busy_cyc++;
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic run_job(input logic [3:0] ax, ay, ar, bx, by, br, cx, cy, cr,
                           input logic [2:0] m, output logic [CNT_W-1:0] cand,
                           output int lat, output bit seen, output int busy_cyc);
        drive_job(ax, ay, ar, bx, by, br, cx, cy, cr, m);
        wait_valid(0, lat, seen, busy_cyc);
        cand = bus_if.candidate;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus_if.en      = 1'b0;
        bus_if.central = '0;
        bus_if.radius  = '0;
        bus_if.mode    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy);
        end
        total++;
        if (bus_if.valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", bus_if.valid);
        end
        total++;
        if (bus_if.candidate !== '0) begin
            bad++; $display("FAIL reset_candidate got=%0d exp=0", bus_if.candidate);
        end
`ifdef CIRCLE_SET_ROWMASK_EN
        total++;
        if (bus_if.row_mask_vld !== 1'b0) begin
            bad++; $display("FAIL reset_row_mask_vld got=%b exp=0", bus_if.row_mask_vld);
        end
`endif
    endtask

    task automatic test_single_circle();
        logic [3:0]       cx [4] = '{4'd4, 4'd1, 4'd4, 4'd0};
        logic [3:0]       cy [4] = '{4'd4, 4'd1, 4'd4, 4'd0};
        logic [3:0]       cr [4] = '{4'd3, 4'd15, 4'd0, 4'd0};
        int               ex [4] = '{29, 64, 1, 0};
        logic [CNT_W-1:0] cand;
        int               lat, bcyc;
        bit               seen;
        for (int i = 0; i < 4; i++) begin
            run_job(cx[i], cy[i], cr[i], 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                    3'd0, cand, lat, seen, bcyc);
            total++;
            if (!seen) begin
                bad++; $display("FAIL single_%0d_timeout got=no_valid exp=valid", i);
            end
            total++;
            if (cand !== CNT_W'(ex[i])) begin
                bad++; $display("FAIL single_%0d_count got=%0d exp=%0d", i, cand, ex[i]);
            end
            if (i == 0) begin
                total++;
                if (lat != GRID) begin
                    bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, GRID);
                end
                total++;
                if (bcyc != GRID) begin
                    bad++; $display("FAIL single_busy_cycles got=%0d exp=%0d", bcyc, GRID);
                end
            end
            @(negedge clk);
            total++;
            if (bus_if.valid !== 1'b0) begin
                bad++; $display("FAIL single_%0d_valid_width got=%b exp=0", i, bus_if.valid);
            end
        end
    endtask

    task automatic test_set_modes();
        // Three identical discs, then two overlapping discs with C off-lattice.
        logic [2:0]       m_same [6] = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        int               e_same [6] = '{29, 0, 0, 29, 29, 0};
        logic [2:0]       m_ovl  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        int               e_ovl  [6] = '{5, 16, 5, 21, 0, 5};
        logic [CNT_W-1:0] cand;
        int               lat, bcyc;
        bit               seen;
        for (int i = 0; i < 6; i++) begin
            run_job(4'd4, 4'd4, 4'd3, 4'd4, 4'd4, 4'd3, 4'd4, 4'd4, 4'd3,
                    m_same[i], cand, lat, seen, bcyc);
            total++;
            if (!seen || cand !== CNT_W'(e_same[i])) begin
                bad++; $display("FAIL same_mode%0d got=%0d seen=%b exp=%0d",
                                m_same[i], cand, seen, e_same[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            run_job(4'd3, 4'd4, 4'd2, 4'd5, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0,
                    m_ovl[i], cand, lat, seen, bcyc);
            total++;
            if (!seen || cand !== CNT_W'(e_ovl[i])) begin
                bad++; $display("FAIL overlap_mode%0d got=%0d seen=%b exp=%0d",
                                m_ovl[i], cand, seen, e_ovl[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  lat, bcyc;
        bit  seen;
        drive_job(4'd4, 4'd4, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        repeat (3) @(negedge clk);
        // en while busy, with a job that would count 64 if accepted.
        bus_if.central = {4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        bus_if.radius  = {4'd15, 4'd0, 4'd0};
        bus_if.en      = 1'b1;
        @(negedge clk);
        bus_if.en      = 1'b0;
        total++;
        if (bus_if.busy !== 1'b1) begin
            bad++; $display("FAIL ignore_busy got=%b exp=1", bus_if.busy);
        end
        wait_valid(4, lat, seen, bcyc);
        total++;
        if (!seen || lat != GRID) begin
            bad++; $display("FAIL ignore_latency got=%0d seen=%b exp=%0d", lat, seen, GRID);
        end
        total++;
        if (bus_if.candidate !== CNT_W'(29)) begin
            bad++; $display("FAIL ignore_count got=%0d exp=29", bus_if.candidate);
        end
        // New job issued in the valid cycle.
        drive_job(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        total++;
        if (bus_if.busy !== 1'b1 || bus_if.valid !== 1'b0) begin
            bad++; $display("FAIL b2b_accept got=busy%b/valid%b exp=busy1/valid0",
                            bus_if.busy, bus_if.valid);
        end
        total++;
        if (bus_if.candidate !== CNT_W'(29)) begin
            bad++; $display("FAIL b2b_hold got=%0d exp=29", bus_if.candidate);
        end
        wait_valid(0, lat, seen, bcyc);
        total++;
        if (!seen || lat != GRID) begin
            bad++; $display("FAIL b2b_latency got=%0d seen=%b exp=%0d", lat, seen, GRID);
        end
        total++;
        if (bus_if.candidate !== CNT_W'(1)) begin
            bad++; $display("FAIL b2b_count got=%0d exp=1", bus_if.candidate);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid_scan();
        int strobes;
        drive_job(4'd4, 4'd4, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus_if.busy !== 1'b0 || bus_if.valid !== 1'b0 || bus_if.candidate !== '0) begin
            bad++; $display("FAIL rst_mid got=busy%b/valid%b/cand%0d exp=busy0/valid0/cand0",
                            bus_if.busy, bus_if.valid, bus_if.candidate);
        end
        strobes = 0;
        for (int i = 0; i < 2 * GRID; i++) begin
            if (bus_if.valid === 1'b1) strobes++;
            @(negedge clk);
        end
        total++;
        if (strobes != 0) begin
            bad++; $display("FAIL rst_no_valid got=%0d exp=0", strobes);
        end
    endtask

`ifdef CIRCLE_SET_ROWMASK_EN
    task automatic test_row_mask();
        int              pulses;
        logic [GRID-1:0] mask_y1, mask_y4;
        pulses  = 0;
        mask_y1 = '0;
        mask_y4 = '0;
        drive_job(4'd4, 4'd4, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        for (int n = 0; n < 2 * GRID; n++) begin
            if (bus_if.row_mask_vld === 1'b1) pulses++;
            if (n == 1) mask_y1 = bus_if.row_mask;
            if (n == 4) mask_y4 = bus_if.row_mask;
            @(negedge clk);
        end
        total++;
        if (mask_y1 !== 8'b0000_1000) begin
            bad++; $display("FAIL row_mask_y1 got=%b exp=00001000", mask_y1);
        end
        total++;
        if (mask_y4 !== 8'b0111_1111) begin
            bad++; $display("FAIL row_mask_y4 got=%b exp=01111111", mask_y4);
        end
        total++;
        if (pulses != GRID) begin
            bad++; $display("FAIL row_mask_pulses got=%0d exp=%0d", pulses, GRID);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_single_circle();
        test_set_modes();
        test_back_to_back();
        test_rst_mid_scan();
`ifdef CIRCLE_SET_ROWMASK_EN
        test_row_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
